slave_out: RTL and testbench

- Slave-side serial read transmitter; directly upstream of the master receive port.
- On a read request from the slave controller it fetches words from the slave's local memory and handshakes with the master (master_ready/slave_valid).
- Streams burst_num+1 words, DATA_LEN bits each, LSB first, back-to-back on tx_data, one bit per clock.
- Output timing matches the master receiver: the master samples the first bit on the first edge after the handshake edge.

---
 rtl/slave_out_pkg.sv | 18 +
 rtl/slave_piso.sv | 55 +++++
 rtl/slave_out.sv | 177 +++++++++++++++++
 tb/tb_slave_out.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_out_pkg.sv
// Shared definitions for the slave read path.
// Holds the default word/burst/address widths used by the master receive
// port, the slave controller and this transmitter, plus the FSM state type.
package slave_out_pkg;

    localparam int unsigned DEF_DATA_LEN  = 8;
    localparam int unsigned DEF_BURST_LEN = 12;
    localparam int unsigned DEF_ADDR_LEN  = 12;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_HANDSHAKE = 3'd3,
        ST_TRANSMIT  = 3'd4
    } state_t;

endpackage

// File: rtl/slave_piso.sv
// Parallel-in serial-out register for the slave read path.
// Holds the word currently being shifted out (shreg) and the prefetched next
// word (nxt_buf).
//   clk, reset : clock, asynchronous active-low reset
//   load       : shreg <= din
//   shift      : shreg shifts right by one (LSB first out)
//   buf_load   : nxt_buf <= din
//   reload     : shreg <= next word already shifted by one, since its bit 0
//                goes straight to the serial output register upstream
//   din        : parallel data from memory
//   sout       : current LSB of shreg
//   next_lsb   : LSB of the next word (bypassed from din while it is captured)
module slave_piso
    import slave_out_pkg::*;
#(
    parameter int unsigned DATA_LEN = DEF_DATA_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic                buf_load,
    input  logic                reload,
    input  logic [DATA_LEN-1:0] din,
    output logic                sout,
    output logic                next_lsb
);

    logic [DATA_LEN-1:0] shreg;
    logic [DATA_LEN-1:0] nxt_buf;
    logic [DATA_LEN-1:0] reload_src;

    // With very short words the capture and the word boundary can fall on
    // the same edge; forward memory data directly in that case.
    assign reload_src = buf_load ? din : nxt_buf;
    assign sout       = shreg[0];
    assign next_lsb   = reload_src[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            nxt_buf <= '0;
        end else begin
            if (buf_load)
                nxt_buf <= din;
            if (load)
                shreg <= din;
            else if (reload)
                shreg <= reload_src >> 1;
            else if (shift)
                shreg <= shreg >> 1;
        end
    end

endmodule

// File: rtl/slave_out.sv
// Slave-side serial read transmitter.
// Fetches burst_num+1 words from local memory starting at addr, handshakes
// with the master (slave_valid/master_ready) and then streams every word LSB
// first on tx_data, one bit per clock, with no gaps between words.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : read request pulse (addr, burst_num sampled with it)
//   addr         : base memory address
//   burst_num    : extra words; total words = burst_num+1
//   master_ready : master ready for data (only used for the handshake)
//   mem_rdata    : memory data, valid the cycle after mem_rd_en
//   mem_rd_en    : registered memory read strobe
//   mem_addr     : registered memory read address
//   slave_valid  : high from the handshake request to the last bit
//   tx_data      : serial data to the master
//   tx_done      : high while idle
//   busy         : inverse of tx_done
module slave_out
    import slave_out_pkg::*;
#(
    parameter int unsigned DATA_LEN  = DEF_DATA_LEN,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    parameter int unsigned ADDR_LEN  = DEF_ADDR_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_LEN-1:0]  addr,
    input  logic [BURST_LEN-1:0] burst_num,
    input  logic                 master_ready,
    input  logic [DATA_LEN-1:0]  mem_rdata,
    output logic                 mem_rd_en,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic                 slave_valid,
    output logic                 tx_data,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int unsigned BIT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam int unsigned WC_W  = BURST_LEN + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);
    // Prefetch issued at bit 0 returns data two edges later.
    localparam logic [BIT_W-1:0] CAPT_BIT = BIT_W'(2);

    state_t state, state_next;

    logic [ADDR_LEN-1:0]  addr_cnt;
    logic [BURST_LEN-1:0] burst;
    logic [WC_W-1:0]      word_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 more_words;

    logic do_start, do_load, do_hs, do_shift;
    logic do_prefetch, do_capture, do_reload, do_finish;
    logic sout, next_lsb;

    assign more_words = word_cnt < {1'b0, burst};
    assign tx_done    = (state == ST_IDLE);
    assign busy       = ~tx_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        do_start    = 1'b0;
        do_load     = 1'b0;
        do_hs       = 1'b0;
        do_shift    = 1'b0;
        do_prefetch = 1'b0;
        do_capture  = 1'b0;
        do_reload   = 1'b0;
        do_finish   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    do_start   = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                do_load    = 1'b1;
                state_next = ST_HANDSHAKE;
            end
            ST_HANDSHAKE: begin
                if (master_ready && slave_valid) begin
                    do_hs      = 1'b1;
                    state_next = ST_TRANSMIT;
                end
            end
            ST_TRANSMIT: begin
                do_prefetch = (bit_cnt == '0) && more_words;
                do_capture  = (bit_cnt == CAPT_BIT) && more_words;
                if (bit_cnt == LAST_BIT) begin
                    if (more_words) begin
                        do_reload = 1'b1;
                    end else begin
                        do_finish  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    do_shift = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            addr_cnt    <= '0;
            burst       <= '0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            slave_valid <= 1'b0;
            tx_data     <= 1'b0;
        end else begin
            mem_rd_en <= do_start | do_prefetch;
            if (do_start) begin
                mem_addr <= addr;
                addr_cnt <= addr;
                burst    <= burst_num;
            end
            if (do_prefetch)
                mem_addr <= addr_cnt;
            if (do_load || do_capture)
                addr_cnt <= addr_cnt + ADDR_LEN'(1);
            if (do_load) begin
                word_cnt    <= '0;
                slave_valid <= 1'b1;
            end
            // tx_data is registered from shreg[0]; the register then shifts so
            // its LSB is always the bit for the following cycle.
            if (do_hs) begin
                tx_data <= sout;
                bit_cnt <= '0;
            end
            if (do_shift) begin
                tx_data <= sout;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (do_reload) begin
                tx_data  <= next_lsb;
                bit_cnt  <= '0;
                word_cnt <= word_cnt + WC_W'(1);
            end
            if (do_finish) begin
                slave_valid <= 1'b0;
                tx_data     <= 1'b0;
            end
        end
    end

    slave_piso #(
        .DATA_LEN(DATA_LEN)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (do_load),
        .shift    (do_hs | do_shift),
        .buf_load (do_capture),
        .reload   (do_reload),
        .din      (mem_rdata),
        .sout     (sout),
        .next_lsb (next_lsb)
    );

endmodule

// File: tb/tb_slave_out.sv
// Self-checking bench for slave_out: memory model, master receive model and
// a bit/word scoreboard filled from the memory contents at each request.
module tb_slave_out;

    localparam int unsigned DL = 8;
    localparam int unsigned BL = 12;
    localparam int unsigned AL = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AL-1:0] addr = '0;
    logic [BL-1:0] burst_num = '0;
    logic          master_ready = 1'b0;
    logic [DL-1:0] mem_rdata = '0;
    logic          mem_rd_en;
    logic [AL-1:0] mem_addr;
    logic          slave_valid;
    logic          tx_data;
    logic          tx_done;
    logic          busy;

    logic [DL-1:0] mem [0:(1<<AL)-1];

    int n_checks = 0;
    int n_fail   = 0;

    logic          exp_bits[$];
    logic [DL-1:0] exp_words[$];
    logic [AL-1:0] rd_log[$];

    logic          rx_done;
    logic [DL-1:0] rx_word;

    slave_out #(
        .DATA_LEN (DL),
        .BURST_LEN(BL),
        .ADDR_LEN (AL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr        (addr),
        .burst_num   (burst_num),
        .master_ready(master_ready),
        .mem_rdata   (mem_rdata),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .slave_valid (slave_valid),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
    always @(negedge clk) if (mem_rd_en) rd_log.push_back(mem_addr);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need $finish)");
        $fatal(1);
    end

    task automatic start_xfer(input logic [AL-1:0] a, input logic [BL-1:0] b, input bit push);
        logic [AL-1:0] wa;
        if (push) begin
            for (int w = 0; w <= int'(b); w++) begin
                wa = a + AL'(w);
                exp_words.push_back(mem[wa]);
                for (int i = 0; i < DL; i++) exp_bits.push_back(mem[wa][i]);
            end
        end
        start = 1'b1; addr = a; burst_num = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Master receive model: waits for the handshake, samples the first bit on
    // the edge after it, and stops early after max_bits when max_bits > 0.
    task automatic receive(input int nwords, input int max_bits);
        int got, limit;
        logic b_exp;
        logic [DL-1:0] w_exp;
        limit = (max_bits > 0) ? max_bits : nwords * DL;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            if (slave_valid === 1'b1 && master_ready === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (got == 0) begin
            n_fail++;
            $display("FAIL handshake: slave_valid=%0b master_ready=%0b after 200 cycles, need both 1", slave_valid, master_ready);
            return;
        end
        @(posedge clk);
        rx_done = 1'b0;
        rx_word = '0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            b_exp = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
            n_checks++;
            if (tx_data !== b_exp || slave_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_bit %0d: tx_data=%0b slave_valid=%0b, expected tx_data=%0b slave_valid=1", k, tx_data, slave_valid, b_exp);
            end
            rx_word = {tx_data, rx_word[DL-1:1]};
            if (k % DL == DL - 1) begin
                rx_done = 1'b1;
                w_exp = (exp_words.size() > 0) ? exp_words.pop_front() : 'x;
                n_checks++;
                if (rx_word !== w_exp) begin
                    n_fail++;
                    $display("FAIL rx_word %0d: got 0x%02h, expected 0x%02h", k / DL, rx_word, w_exp);
                end
            end
        end
        if (max_bits == 0) begin
            @(negedge clk);
            n_checks++;
            if (tx_done !== 1'b1 || busy !== 1'b0 || slave_valid !== 1'b0 || tx_data !== 1'b0) begin
                n_fail++;
                $display("FAIL end_of_xfer: tx_done=%0b busy=%0b slave_valid=%0b tx_data=%0b, expected 1 0 0 0", tx_done, busy, slave_valid, tx_data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; addr = 12'h123; burst_num = 12'd5;
        repeat (3) @(posedge clk);
        #1; start = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_done !== 1'b1) begin n_fail++; $display("FAIL reset_tx_done: got %0b, expected 1", tx_done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        n_checks++;
        if (slave_valid !== 1'b0) begin n_fail++; $display("FAIL reset_slave_valid: got %0b, expected 0", slave_valid); end
        n_checks++;
        if (tx_data !== 1'b0) begin n_fail++; $display("FAIL reset_tx_data: got %0b, expected 0", tx_data); end
        n_checks++;
        if (mem_rd_en !== 1'b0 || mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem: mem_rd_en=%0b mem_addr=0x%03h, expected 0 0x000", mem_rd_en, mem_addr); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_rd_en !== 1'b0 || tx_done !== 1'b1) begin n_fail++; $display("FAIL reset_start_ignored: mem_rd_en=%0b tx_done=%0b, expected 0 1", mem_rd_en, tx_done); end
    endtask

    task automatic test_single();
        mem[12'h010] = 8'hA5;
        master_ready = 1'b1;
        start_xfer(12'h010, 12'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (slave_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 12'h010) begin
            n_fail++;
            $display("FAIL single_fetch: slave_valid=%0b mem_rd_en=%0b mem_addr=0x%03h, expected 0 1 0x010", slave_valid, mem_rd_en, mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (slave_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_load: slave_valid=%0b mem_rd_en=%0b, expected 0 0", slave_valid, mem_rd_en);
        end
        @(negedge clk);
        n_checks++;
        if (slave_valid !== 1'b1 || tx_data !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: slave_valid=%0b tx_data=%0b busy=%0b 3 cycles after start, expected 1 0 1", slave_valid, tx_data, busy);
        end
        receive(1, 0);
        n_checks++;
        if (rx_done !== 1'b1 || rx_word !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_rx: rx_done=%0b rx_word=0x%02h, expected 1 0xa5", rx_done, rx_word);
        end
    endtask

    task automatic test_burst3();
        int idx;
        mem[12'h020] = 8'h01; mem[12'h021] = 8'h80; mem[12'h022] = 8'hFF;
        master_ready = 1'b1;
        idx = rd_log.size();
        start_xfer(12'h020, 12'd2, 1'b1);
        receive(3, 0);
        n_checks++;
        if (rd_log.size() - idx != 3) begin
            n_fail++;
            $display("FAIL burst3_reads: got %0d reads, expected 3", rd_log.size() - idx);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rd_log[idx+i] !== 12'h020 + AL'(i)) begin
                    n_fail++;
                    $display("FAIL burst3_addr %0d: got 0x%03h, expected 0x%03h", i, rd_log[idx+i], 12'h020 + AL'(i));
                end
            end
        end
    endtask

    task automatic test_stall();
        int got;
        mem[12'h030] = 8'h3C;
        master_ready = 1'b0;
        start_xfer(12'h030, 12'd0, 1'b1);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (slave_valid === 1'b1) begin got = 1; break; end
        end
        n_checks++;
        if (got == 0) begin n_fail++; $display("FAIL stall_valid: slave_valid=%0b after 20 cycles, expected 1", slave_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx_data !== 1'b0 || slave_valid !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold %0d: tx_data=%0b slave_valid=%0b busy=%0b, expected 0 1 1", i, tx_data, slave_valid, busy);
            end
        end
        @(posedge clk); #1;
        master_ready = 1'b1;
        receive(1, 0);
    endtask

    task automatic test_wrap();
        int idx;
        mem[12'hFFF] = 8'h5A; mem[12'h000] = 8'hC3;
        master_ready = 1'b1;
        idx = rd_log.size();
        start_xfer(12'hFFF, 12'd1, 1'b1);
        fork
            receive(2, 0);
            begin
                repeat (8) @(posedge clk);
                #1; start = 1'b1; addr = 12'h100; burst_num = 12'd7;
                @(posedge clk); #1; start = 1'b0;
            end
        join
        n_checks++;
        if (rd_log.size() - idx != 2) begin
            n_fail++;
            $display("FAIL wrap_reads: got %0d reads, expected 2", rd_log.size() - idx);
        end else begin
            n_checks++;
            if (rd_log[idx] !== 12'hFFF || rd_log[idx+1] !== 12'h000) begin
                n_fail++;
                $display("FAIL wrap_addr: got 0x%03h 0x%03h, expected 0xfff 0x000", rd_log[idx], rd_log[idx+1]);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_done !== 1'b1 || slave_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_no_restart: tx_done=%0b slave_valid=%0b, expected 1 0", tx_done, slave_valid);
        end
    endtask

    task automatic test_midreset();
        int idx;
        mem[12'h040] = 8'h11; mem[12'h041] = 8'h22; mem[12'h042] = 8'h33; mem[12'h043] = 8'h44;
        master_ready = 1'b1;
        start_xfer(12'h040, 12'd3, 1'b1);
        receive(4, 12);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (slave_valid !== 1'b0 || tx_data !== 1'b0 || tx_done !== 1'b1 || busy !== 1'b0 ||
            mem_rd_en !== 1'b0 || mem_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_async: sv=%0b tx=%0b done=%0b busy=%0b rd_en=%0b addr=0x%03h, expected 0 0 1 0 0 0x000",
                     slave_valid, tx_data, tx_done, busy, mem_rd_en, mem_addr);
        end
        exp_bits.delete();
        exp_words.delete();
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        idx = rd_log.size();
        start_xfer(12'h040, 12'd3, 1'b1);
        receive(4, 0);
        n_checks++;
        if (rd_log.size() - idx != 4) begin
            n_fail++;
            $display("FAIL midreset_reads: got %0d reads, expected 4", rd_log.size() - idx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rd_log[idx+i] !== 12'h040 + AL'(i)) begin
                    n_fail++;
                    $display("FAIL midreset_addr %0d: got 0x%03h, expected 0x%03h", i, rd_log[idx+i], 12'h040 + AL'(i));
                end
            end
        end
    endtask

    task automatic test_max_burst();
        int idx, cnt;
        master_ready = 1'b1;
        idx = rd_log.size();
        start_xfer(12'h000, '1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (slave_valid === 1'b1) break;
        end
        @(posedge clk);
        cnt = 0;
        do begin
            @(negedge clk);
            if (slave_valid === 1'b1) cnt++;
        end while (slave_valid === 1'b1 && cnt < 40000);
        n_checks++;
        if (cnt != (1 << BL) * DL) begin
            n_fail++;
            $display("FAIL max_burst_len: got %0d bit cycles, expected %0d", cnt, (1 << BL) * DL);
        end
        n_checks++;
        if (rd_log.size() - idx != (1 << BL) || tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL max_burst_reads: got %0d reads tx_done=%0b, expected %0d reads tx_done=1", rd_log.size() - idx, tx_done, 1 << BL);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AL); i++) mem[i] = DL'(i * 7 + 3);
        test_reset();
        test_single();
        test_burst3();
        test_stall();
        test_wrap();
        test_midreset();
        test_max_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
